// File: rtl/string_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : string_op_sequencer
// Description : Sequencing controller for the string accelerator. Drains the
//               A (and for STRCMP the B) string FIFO one word per fetch and
//               walks each word one byte per cycle, MSB byte first. Runs
//               STRLEN(A) or STRCMP(A,B) and latches a 32-bit result together
//               with sticky done/error flags.
// Ports       : clk, reset           - clock, async active-high reset
//               go, op               - start pulse / 0=STRLEN 1=STRCMP
//               a_empty, a_rdata     - FIFO A show-ahead head; a_pop pops it
//               b_empty, b_rdata     - FIFO B show-ahead head; b_pop pops it
//               busy, done, error    - status
//               result               - byte count or signed byte difference
// Revision    : 1.0 - initial release
// ============================================================================
module string_op_sequencer #(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        op,
    input  logic        a_empty,
    input  logic [31:0] a_rdata,
    output logic        a_pop,
    input  logic        b_empty,
    input  logic [31:0] b_rdata,
    output logic        b_pop,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_FETCH = 2'd1;
    localparam logic [1:0]  S_SCAN  = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam logic [31:0] c_OVERRUN_RESULT = 32'hDEADFACE;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_op;
    logic [31:0]      r_a_word;
    logic [31:0]      r_b_word;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_error;
    logic [31:0]      r_result;

    logic             w_go_ok;
    logic             w_fetch_ok;
    logic [31:0]      w_a_shift;
    logic [31:0]      w_b_shift;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic             w_differ;
    logic             w_term;
    logic             w_overrun;
    logic [8:0]       w_diff;

    // go is only honoured while not running
    assign w_go_ok    = go && ((r_state == S_IDLE) || (r_state == S_DONE));
    // STRCMP needs both heads present so the strings advance in lock-step
    assign w_fetch_ok = !a_empty && (!r_op || !b_empty);

    // Current byte: shift the selected byte up to [31:24]
    assign w_a_shift  = r_a_word << {r_idx, 3'b000};
    assign w_b_shift  = r_b_word << {r_idx, 3'b000};
    assign w_a_byte   = w_a_shift[31:24];
    assign w_b_byte   = w_b_shift[31:24];
    assign w_differ   = (w_a_byte != w_b_byte);
    // For STRCMP, equal bytes with A==0 means both are NUL
    assign w_term     = r_op ? (w_differ || (w_a_byte == 8'h00)) : (w_a_byte == 8'h00);
    assign w_overrun  = (r_idx == 2'd3) && !w_term && (r_word_cnt == CNT_W'(MAX_WORDS));
    // 9-bit two's complement difference of the zero-extended bytes
    assign w_diff     = {1'b0, w_a_byte} - {1'b0, w_b_byte};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (go) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_fetch_ok) w_next_state = S_SCAN;
            end
            S_SCAN: begin
                if (w_term || w_overrun) w_next_state = S_DONE;
                else if (r_idx == 2'd3)  w_next_state = S_FETCH;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs; pops are gated by the empty flags through w_fetch_ok
    always_comb begin
        a_pop  = (r_state == S_FETCH) && w_fetch_ok;
        b_pop  = (r_state == S_FETCH) && w_fetch_ok && r_op;
        busy   = (r_state == S_FETCH) || (r_state == S_SCAN);
        done   = (r_state == S_DONE);
        error  = r_error;
        result = r_result;
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= 1'b0;
            r_a_word   <= '0;
            r_b_word   <= '0;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_error    <= 1'b0;
            r_result   <= '0;
        end else begin
            if (w_go_ok) begin
                r_op       <= op;
                r_result   <= '0;
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_error    <= 1'b0;
            end else if ((r_state == S_FETCH) && w_fetch_ok) begin
                r_a_word   <= a_rdata;
                r_b_word   <= r_op ? b_rdata : 32'h0;
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                r_idx      <= 2'd0;
            end else if (r_state == S_SCAN) begin
                if (w_term) begin
                    if (r_op) r_result <= w_differ ? {{23{w_diff[8]}}, w_diff} : 32'h0;
                    else      r_result <= 32'(r_byte_cnt);
                end else if (w_overrun) begin
                    r_error  <= 1'b1;
                    r_result <= c_OVERRUN_RESULT;
                end else begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    r_idx      <= r_idx + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_string_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_string_op_sequencer
// Description : Self-checking bench for string_op_sequencer. Behavioural
//               show-ahead FIFOs feed the DUT; a reference model computes the
//               expected result per operation, which is queued at go and
//               compared when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_string_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        op;
    logic        a_empty;
    logic [31:0] a_rdata;
    logic        a_pop;
    logic        b_empty;
    logic [31:0] b_rdata;
    logic        b_pop;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    string_op_sequencer #(.MAX_WORDS(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .op      (op),
        .a_empty (a_empty),
        .a_rdata (a_rdata),
        .a_pop   (a_pop),
        .b_empty (b_empty),
        .b_rdata (b_rdata),
        .b_pop   (b_pop),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Behavioural FIFOs: written by the stimulus, read pointer moved on pop
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
    int a_pops = 0, b_pops = 0, pop_viol = 0;

    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_rdata = a_mem[a_rd[7:0]];
    assign b_rdata = b_mem[b_rd[7:0]];

    always @(posedge clk) begin
        if (a_pop) begin
            a_pops <= a_pops + 1;
            if (a_wr == a_rd) pop_viol <= pop_viol + 1;
            else              a_rd <= a_rd + 1;
        end
        if (b_pop) begin
            b_pops <= b_pops + 1;
            if (b_wr == b_rd) pop_viol <= pop_viol + 1;
            else              b_rd <= b_rd + 1;
        end
    end

    // Stimulus strings for the next operation
    logic [31:0] am [4];
    logic [31:0] bm [4];

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          apops;
        int          bpops;
    } exp_t;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model over am/bm: result, error and words consumed
    function automatic void model(input bit opv, output logic [31:0] res,
                                  output bit err, output int words);
        int cnt = 0;
        logic [7:0] ab, bb;
        err = 1'b0;
        res = 32'h0;
        words = 4;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                ab = 8'(am[w] >> (24 - 8 * k));
                bb = 8'(bm[w] >> (24 - 8 * k));
                if (!opv && ab == 8'h00) begin
                    res = 32'(cnt); words = w + 1; return;
                end
                if (opv && ab != bb) begin
                    res = 32'(int'(ab) - int'(bb)); words = w + 1; return;
                end
                if (opv && ab == 8'h00) begin
                    res = 32'h0; words = w + 1; return;
                end
                cnt++;
            end
        end
        err = 1'b1;
        res = 32'hDEADFACE;
    endfunction

    task automatic load(input bit opv, input int n);
        for (int i = 0; i < n; i++) begin
            a_mem[a_wr[7:0]] = am[i];
            a_wr = a_wr + 1;
            if (opv) begin
                b_mem[b_wr[7:0]] = bm[i];
                b_wr = b_wr + 1;
            end
        end
    endtask

    task automatic pulse_go(input bit opv);
        @(negedge clk);
        op = opv;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // One operation: queue expectation, start, optionally stall FIFOs, compare at done
    task automatic run(input bit opv, input int stall, input int exp_lat, input string tag);
        logic [31:0] r;
        bit e;
        int w, a0, b0, cnt;
        exp_t x;
        model(opv, r, e, w);
        x.res = r; x.err = e; x.apops = w; x.bpops = opv ? w : 0;
        sb.push_back(x);
        a0 = a_pops;
        b0 = b_pops;
        if (stall == 0) load(opv, w);
        pulse_go(opv);
        if (stall > 0) begin
            repeat (stall - 2) @(negedge clk);
            go = 1'b1;                      // must be ignored while busy
            @(negedge clk);
            go = 1'b0;
            @(negedge clk);
            chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
            chk({tag, "_stall_nopop"}, 32'(a_pops - a0), 32'd0);
            chk({tag, "_stall_notdone"}, 32'(done), 32'd0);
            load(opv, w);
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        x = sb.pop_front();
        chk({tag, "_result"}, result, x.res);
        chk({tag, "_error"}, 32'(error), 32'(x.err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_apops"}, 32'(a_pops - a0), 32'(x.apops));
        chk({tag, "_bpops"}, 32'(b_pops - b0), 32'(x.bpops));
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    endtask

    initial begin
        int a0, cnt;
        reset = 1'b1;
        go    = 1'b0;
        op    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_error",  32'(error), 32'd0);
        chk("rst_result", result,     32'd0);
        chk("rst_apop",   32'(a_pop), 32'd0);
        chk("rst_bpop",   32'(b_pop), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        am = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        bm = '{32'h0, 32'h0, 32'h0, 32'h0};
        run(1'b0, 0, 5, "strlen_abc");

        am = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        bm = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        run(1'b1, 0, 5, "strcmp_eq");

        am = '{32'h41434300, 32'h0, 32'h0, 32'h0};
        bm = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        run(1'b1, 0, 3, "strcmp_pos");

        am = '{32'h41000000, 32'h0, 32'h0, 32'h0};
        bm = '{32'h42000000, 32'h0, 32'h0, 32'h0};
        run(1'b1, 0, 2, "strcmp_neg");

        am = '{32'h61616161, 32'h61616161, 32'h61616161, 32'h61616161};
        run(1'b0, 0, -1, "overrun");

        am = '{32'h61616161, 32'h62620000, 32'h0, 32'h0};
        run(1'b0, 0, -1, "strlen_2w");

        am = '{32'h41420000, 32'h0, 32'h0, 32'h0};
        run(1'b0, 10, -1, "stall");

        am = '{32'h00FF0000, 32'h0, 32'h0, 32'h0};
        bm = '{32'hFF000000, 32'h0, 32'h0, 32'h0};
        run(1'b1, 0, 2, "strcmp_nul_vs_ff");

        // Reset in the middle of scanning the second word
        am = '{32'h61616161, 32'h61616161, 32'h0, 32'h0};
        a0 = a_pops;
        load(1'b0, 2);
        pulse_go(1'b0);
        cnt = 0;
        while (a_pops < a0 + 2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("midrst_second_pop", 32'(a_pops - a0), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   32'(busy),  32'd0);
        chk("midrst_done",   32'(done),  32'd0);
        chk("midrst_error",  32'(error), 32'd0);
        chk("midrst_result", result,     32'd0);
        chk("midrst_apop",   32'(a_pop), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_fifo_empty", 32'(a_empty), 32'd1);

        am = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        run(1'b0, 0, 5, "post_reset");

        chk("pop_while_empty", 32'(pop_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
